// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the uDLX instruction fetch stage:
//   - default instruction / PC widths, reset PC and sequential PC step
//   - NOP encoding (all-zero word) used as the IF/ID bubble
//   - fetch FSM state encoding (IDLE / FETCH / HALT, 2 bits)
//   - helper that flags a branch target that is not word aligned
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int unsigned IF_INSTRUCTION_WIDTH = 32;
  localparam int unsigned IF_PC_WIDTH          = 32;
  localparam int unsigned IF_PC_STEP           = 4;

  // The decoder treats an all-zero word as a no-operation.
  localparam int unsigned IF_NOP_VALUE = 0;

  typedef enum logic [1:0] {
    IF_ST_IDLE  = 2'b00,
    IF_ST_FETCH = 2'b01,
    IF_ST_HALT  = 2'b10
  } if_state_e;

  // Instructions are 32-bit aligned, so any set bit in the low two address
  // bits of a branch target is a fatal fetch error.
  function automatic logic if_target_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// Owns the fetch PC register. A load has priority over an increment; the
// increment wraps modulo 2^PC_WIDTH by plain truncation.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   load_en_i        : load load_value_i into the PC this cycle
//   load_value_i     : redirect address
//   inc_en_i         : advance the PC by PC_STEP this cycle
//   pc_o             : current PC
//   pc_next_seq_o    : PC + PC_STEP (wrapped), the next sequential address
// ---------------------------------------------------------------------------
module program_counter
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned            PC_WIDTH       = IF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]    PC_RESET_VALUE = '0,
  parameter int unsigned            PC_STEP        = IF_PC_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en_i,
  input  logic [PC_WIDTH-1:0] load_value_i,
  input  logic                inc_en_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [PC_WIDTH-1:0] pc_next_seq_o
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  // Sum is truncated to PC_WIDTH bits, giving the modulo wrap for free.
  assign pc_next_seq_o = pc_q + STEP;
  assign pc_o          = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en_i) begin
      pc_d = load_value_i;
    end else if (inc_en_i) begin
      pc_d = pc_next_seq_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET_VALUE;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// First pipeline stage of the uDLX core. Holds the PC (in program_counter),
// requests words from a single-cycle instruction memory and captures them
// into the IF/ID register that feeds the decoder. Handles stall, flush and
// branch redirect, and halts permanently (until reset) on a misaligned
// branch target.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall_in            : hold PC and IF/ID register
//   flush_in            : replace IF/ID contents with a bubble
//   branch_taken_in     : redirect PC to branch_target_in (implies flush)
//   branch_target_in    : redirect address
//   imem_req_out        : fetch request
//   imem_addr_out       : fetch address (always the current PC)
//   imem_ready_in       : imem_data_in is valid this cycle
//   imem_data_in        : fetched word
//   instruction_out     : IF/ID instruction
//   pc_out              : IF/ID next-sequential PC (fetch PC + PC_STEP)
//   valid_out           : IF/ID holds a real instruction
//   fetch_error_out     : sticky misaligned-target error
//   fsm_state_out       : debug view of the fetch FSM state
//   perf_fetched_out    : (IF_PERF_COUNTERS_EN) accepted-word count
//   perf_bubbles_out    : (IF_PERF_COUNTERS_EN) bubble count
//
// Handshake: a word is accepted on a rising edge where imem_req_out and
// imem_ready_in are both high; imem_data_in is sampled on that same edge.
// imem_ready_in carries no meaning while imem_req_out is low.
//
// Optional feature macro: IF_PERF_COUNTERS_EN adds two saturating 32-bit
// performance counters and their output ports.
// ---------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned         INSTRUCTION_WIDTH = IF_INSTRUCTION_WIDTH,
  parameter int unsigned         PC_WIDTH          = IF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] PC_RESET_VALUE    = '0,
  parameter int unsigned         PC_STEP           = IF_PC_STEP
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall_in,
  input  logic                         flush_in,
  input  logic                         branch_taken_in,
  input  logic [PC_WIDTH-1:0]          branch_target_in,
  output logic                         imem_req_out,
  output logic [PC_WIDTH-1:0]          imem_addr_out,
  input  logic                         imem_ready_in,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic                         valid_out,
  output logic                         fetch_error_out,
`ifdef IF_PERF_COUNTERS_EN
  output logic [31:0]                  perf_fetched_out,
  output logic [31:0]                  perf_bubbles_out,
`endif
  output if_state_e                    fsm_state_out
);

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(IF_NOP_VALUE);

  // -------------------------------------------------------------------------
  // State and IF/ID register
  // -------------------------------------------------------------------------
  if_state_e                    state_q, state_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]          pc_seq_q, pc_seq_d;
  logic                         valid_q, valid_d;
  logic                         error_q, error_d;

  // Program counter control
  logic                pc_load_en;
  logic                pc_inc_en;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next_seq;

  // Event strobes, also used by the optional counters
  logic accept;
  logic bubble;

  program_counter #(
    .PC_WIDTH       (PC_WIDTH),
    .PC_RESET_VALUE (PC_RESET_VALUE),
    .PC_STEP        (PC_STEP)
  ) u_program_counter (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_en_i     (pc_load_en),
    .load_value_i  (branch_target_in),
    .inc_en_i      (pc_inc_en),
    .pc_o          (pc),
    .pc_next_seq_o (pc_next_seq)
  );

  // -------------------------------------------------------------------------
  // Memory request
  // -------------------------------------------------------------------------
  assign imem_req_out  = (state_q == IF_ST_FETCH) && !stall_in
                         && !branch_taken_in && !flush_in;
  assign imem_addr_out = pc;

  // -------------------------------------------------------------------------
  // Next-state / IF/ID update, priority: branch > flush > stall > accept
  // > wait-for-memory.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_seq_d   = pc_seq_q;
    valid_d    = valid_q;
    error_d    = error_q;
    pc_load_en = 1'b0;
    pc_inc_en  = 1'b0;
    accept     = 1'b0;
    bubble     = 1'b0;

    unique case (state_q)
      IF_ST_IDLE: begin
        state_d = IF_ST_FETCH;
      end

      IF_ST_FETCH: begin
        if (branch_taken_in) begin
          bubble  = 1'b1;
          valid_d = 1'b0;
          if (if_target_misaligned(branch_target_in[1:0])) begin
            // Fatal: the PC is left alone and the stage stops fetching.
            state_d = IF_ST_HALT;
            error_d = 1'b1;
          end else begin
            instr_d    = NOP;
            pc_load_en = 1'b1;
          end
        end else if (flush_in) begin
          bubble  = 1'b1;
          instr_d = NOP;
          valid_d = 1'b0;
        end else if (stall_in) begin
          // Everything holds.
        end else if (imem_ready_in) begin
          // imem_req_out is necessarily high on this branch.
          accept    = 1'b1;
          instr_d   = imem_data_in;
          pc_seq_d  = pc_next_seq;
          valid_d   = 1'b1;
          pc_inc_en = 1'b1;
        end else begin
          bubble  = 1'b1;
          valid_d = 1'b0;
        end
      end

      IF_ST_HALT: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = IF_ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IF_ST_IDLE;
      instr_q  <= NOP;
      pc_seq_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_seq_q <= pc_seq_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign instruction_out = instr_q;
  assign pc_out          = pc_seq_q;
  assign valid_out       = valid_q;
  assign fetch_error_out = error_q;
  assign fsm_state_out   = state_q;

`ifdef IF_PERF_COUNTERS_EN
  // -------------------------------------------------------------------------
  // Saturating performance counters
  // -------------------------------------------------------------------------
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (accept && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (bubble && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched_out = perf_fetched_q;
  assign perf_bubbles_out = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Directed walk through the fetch stage's main scenarios followed by a
// randomized stretch, all checked against a cycle-level reference model
// of the stage's rules (PC, IF/ID contents, halt/error).
// ---------------------------------------------------------------------------
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // DUT signals
  // -------------------------------------------------------------------------
  logic        stall_in;
  logic        flush_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready_in;
  logic [31:0] imem_data_in;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        fetch_error_out;
  if_state_e   fsm_state_out;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_out;
  logic [31:0] perf_bubbles_out;
`endif

  instruction_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_in         (stall_in),
    .flush_in         (flush_in),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .imem_req_out     (imem_req_out),
    .imem_addr_out    (imem_addr_out),
    .imem_ready_in    (imem_ready_in),
    .imem_data_in     (imem_data_in),
    .instruction_out  (instruction_out),
    .pc_out           (pc_out),
    .valid_out        (valid_out),
    .fetch_error_out  (fetch_error_out),
`ifdef IF_PERF_COUNTERS_EN
    .perf_fetched_out (perf_fetched_out),
    .perf_bubbles_out (perf_bubbles_out),
`endif
    .fsm_state_out    (fsm_state_out)
  );

  // -------------------------------------------------------------------------
  // Reference model: what the stage should hold after each clock
  // -------------------------------------------------------------------------
  logic [31:0] m_pc;       // address being fetched
  logic [31:0] m_instr;    // IF/ID instruction
  logic [31:0] m_pcout;    // IF/ID next-sequential PC
  logic        m_valid;
  logic        m_err;
  logic        m_started;  // the one idle cycle after reset is over
  logic        m_halted;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_instr   = 32'h0;
    m_pcout   = 32'h0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
    m_started = 1'b0;
    m_halted  = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".instr"}, instruction_out, m_instr);
    check({tag, ".pc_out"}, pc_out, m_pcout);
    check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    check({tag, ".err"}, 32'(fetch_error_out), 32'(m_err));
  endtask

  // Asynchronous reset, checked before any clock edge can occur.
  task automatic do_reset();
    stall_in         = 1'b0;
    flush_in         = 1'b0;
    branch_taken_in  = 1'b0;
    branch_target_in = 32'h0;
    imem_ready_in    = 1'b0;
    imem_data_in     = 32'h0;
    rst_n            = 1'b0;
    #2;
    model_reset();
    check_regs("reset");
    check("reset.req", 32'(imem_req_out), 32'h0);
    check("reset.addr", imem_addr_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus: drive, check request side, clock, check IF/ID.
  task automatic cycle(input string tag, input logic s, input logic f, input logic b,
                       input logic [31:0] t, input logic r, input logic [31:0] d);
    logic exp_req;
    stall_in         = s;
    flush_in         = f;
    branch_taken_in  = b;
    branch_target_in = t;
    imem_ready_in    = r;
    imem_data_in     = d;
    #1;
    exp_req = m_started && !m_halted && !s && !f && !b;
    check({tag, ".req"}, 32'(imem_req_out), 32'(exp_req));
    check({tag, ".addr"}, imem_addr_out, m_pc);

    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (b) begin
      m_valid = 1'b0;
      if (t % 4 != 0) begin
        m_halted = 1'b1;
        m_err    = 1'b1;
      end else begin
        m_pc    = t;
        m_instr = 32'h0;
      end
    end else if (f) begin
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else if (s) begin
      // hold
    end else if (r) begin
      m_instr = d;
      m_pcout = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end else begin
      m_valid = 1'b0;
    end

    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst_n = 1'b1;
    model_reset();
    #1;
    do_reset();

    // Idle cycle, then three sequential fetches with stall at 0x8.
    cycle("idle", 0, 0, 0, 32'h0, 1, 32'h0);
    cycle("seq0", 0, 0, 0, 32'h0, 1, 32'hA000_0001);
    check("seq0.pc_out_const", pc_out, 32'h4);
    cycle("seq1", 0, 0, 0, 32'h0, 1, 32'hA000_0002);
    check("seq1.instr_const", instruction_out, 32'hA000_0002);
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1, 0, 0, 32'h0, 1, $urandom);
    end
    check("stall.addr_const", imem_addr_out, 32'h8);
    check("stall.instr_const", instruction_out, 32'hA000_0002);
    cycle("seq2", 0, 0, 0, 32'h0, 1, 32'hA000_0003);
    check("seq2.pc_out_const", pc_out, 32'hC);

    // Branch wins over stall.
    cycle("br_stall", 1, 0, 1, 32'h100, 1, $urandom);
    check("br_stall.addr_const", imem_addr_out, 32'h100);
    check("br_stall.valid_const", 32'(valid_out), 32'h0);
    cycle("br_fetch", 0, 0, 0, 32'h0, 1, 32'hB000_0100);
    cycle("flush", 0, 1, 0, 32'h0, 1, $urandom);

    // Memory not ready at 0x10.
    cycle("br_10", 0, 0, 1, 32'h10, 1, $urandom);
    cycle("wait0", 0, 0, 0, 32'h0, 0, $urandom);
    cycle("wait1", 0, 0, 0, 32'h0, 0, $urandom);
    check("wait.addr_const", imem_addr_out, 32'h10);
    cycle("wait_acc", 0, 0, 0, 32'h0, 1, 32'hC000_0010);
    check("wait_acc.pc_out_const", pc_out, 32'h14);

    // PC wrap at the top of the address space.
    cycle("br_top", 0, 0, 1, 32'hFFFF_FFFC, 1, $urandom);
    cycle("wrap", 0, 0, 0, 32'h0, 1, 32'hD000_0000);
    check("wrap.pc_out_const", pc_out, 32'h0);
    check("wrap.addr_const", imem_addr_out, 32'h0);

    // Misaligned target: halt with sticky error, then recover by reset.
    cycle("br_bad", 0, 0, 1, 32'h102, 1, $urandom);
    check("halt.err_const", 32'(fetch_error_out), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cycle("halt", $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, $urandom_range(0, 1), $urandom);
    end
    do_reset();
    cycle("re_idle", 0, 0, 0, 32'h0, 1, 32'h0);
    cycle("re_fetch", 0, 0, 0, 32'h0, 1, 32'hE000_0000);

    // Randomized traffic, including mid-run resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        tgt = $urandom;
        if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
        cycle("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 9) == 0), tgt, ($urandom_range(0, 3) != 0), $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
